// File: rtl/uart_msg_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_msg_rx
// Description : 8N1 UART receiver with a line assembler that recognises
//               "Hello World <A-Z>\r\n" lines, reports each terminated line
//               and counts the lines that matched.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_msg_rx #(
   parameter int CLK_FRE   = 27,      // clock frequency in MHz
   parameter int BAUD_RATE = 115200   // line rate in bit/s
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   output logic       rx_frame_err,
   output logic       msg_valid,
   output logic       msg_ok,
   output logic [7:0] msg_letter,
   output logic [7:0] msg_count
);

   // Bit timing derived from the clock and line rate.
   localparam int C_BIT_CYC  = CLK_FRE * 1_000_000 / BAUD_RATE;
   localparam int C_HALF_CYC = C_BIT_CYC / 2;
   localparam int C_CNT_W    = $clog2(C_BIT_CYC + 1);
   localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(C_BIT_CYC - 1);
   localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(C_HALF_CYC - 1);

   localparam logic [7:0] C_CR = 8'h0D;
   localparam logic [7:0] C_LF = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_rx_meta;
   logic               r_rxs;
   logic               r_rxs_d;
   logic [C_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               w_fall;
   logic               w_tick_half;
   logic               w_tick_bit;
   logic               w_stop_good;
   logic               w_stop_bad;

   logic [3:0]         r_idx;
   logic               r_mismatch;
   logic [7:0]         r_cand;
   logic               w_byte_bad;
   logic               w_line_ok;
   logic [7:0]         w_expect;

   // Two-stage synchroniser plus one delay stage for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
         r_rxs_d   <= 1'b1;
      end else begin
         r_rx_meta <= rx_pin;
         r_rxs     <= r_rx_meta;
         r_rxs_d   <= r_rxs;
      end
   end

   assign w_fall      = r_rxs_d & ~r_rxs;
   assign w_tick_half = (r_cnt == C_HALF_LAST);
   assign w_tick_bit  = (r_cnt == C_BIT_LAST);

   // Byte FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Byte FSM next state and stop-bit verdicts.
   always_comb begin
      w_state_nxt = r_state;
      w_stop_good = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (w_tick_half) begin
               w_state_nxt = r_rxs ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_tick_bit && (r_bit_idx == 3'd7)) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_tick_bit) begin
               if (r_rxs) begin
                  w_stop_good = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_stop_bad  = 1'b1;
                  w_state_nxt = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // Ride out a break: nothing is reported until the line idles.
            if (r_rxs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Baud counter, bit index and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         case (r_state)
            S_START: begin
               r_bit_idx <= 3'd0;
               r_cnt     <= w_tick_half ? '0 : r_cnt + 1'b1;
            end
            S_DATA: begin
               if (w_tick_bit) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_rxs, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               r_cnt <= w_tick_bit ? '0 : r_cnt + 1'b1;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   // Byte outputs, registered one cycle after the stop-bit sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data       <= 8'h00;
         rx_data_valid <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_data_valid <= w_stop_good;
         rx_frame_err  <= w_stop_bad;
         if (w_stop_good) begin
            rx_data <= r_shift;
         end
      end
   end

   // Expected character for the current line position.
   always_comb begin
      w_expect = 8'h00;
      case (r_idx)
         4'd0:    w_expect = 8'h48;  // H
         4'd1:    w_expect = 8'h65;  // e
         4'd2:    w_expect = 8'h6C;  // l
         4'd3:    w_expect = 8'h6C;  // l
         4'd4:    w_expect = 8'h6F;  // o
         4'd5:    w_expect = 8'h20;  // space
         4'd6:    w_expect = 8'h57;  // W
         4'd7:    w_expect = 8'h6F;  // o
         4'd8:    w_expect = 8'h72;  // r
         4'd9:    w_expect = 8'h6C;  // l
         4'd10:   w_expect = 8'h64;  // d
         4'd11:   w_expect = 8'h20;  // space
         4'd13:   w_expect = C_CR;
         default: w_expect = 8'h00;
      endcase
   end

   // Does the current non-terminator byte break the template?
   always_comb begin
      w_byte_bad = 1'b0;
      if (r_idx <= 4'd11 || r_idx == 4'd13) begin
         w_byte_bad = (rx_data != w_expect);
      end else if (r_idx == 4'd12) begin
         w_byte_bad = (rx_data < 8'h41) || (rx_data > 8'h5A);
      end else begin
         // Position 14 only accepts the terminator; 15 means overlong.
         w_byte_bad = 1'b1;
      end
   end

   assign w_line_ok = (r_idx == 4'd14) && !r_mismatch;

   // Line assembler driven by the byte-level pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx      <= 4'd0;
         r_mismatch <= 1'b0;
         r_cand     <= 8'h00;
         msg_valid  <= 1'b0;
         msg_ok     <= 1'b0;
         msg_letter <= 8'h00;
         msg_count  <= 8'h00;
      end else begin
         msg_valid <= 1'b0;
         if (rx_data_valid) begin
            if (rx_data == C_LF) begin
               msg_valid  <= 1'b1;
               msg_ok     <= w_line_ok;
               if (w_line_ok) begin
                  msg_letter <= r_cand;
                  msg_count  <= msg_count + 8'd1;
               end
               r_idx      <= 4'd0;
               r_mismatch <= 1'b0;
            end else begin
               if (w_byte_bad) begin
                  r_mismatch <= 1'b1;
               end
               if (r_idx == 4'd12) begin
                  r_cand <= rx_data;
               end
               if (r_idx != 4'd15) begin
                  r_idx <= r_idx + 4'd1;
               end
            end
         end else if (rx_frame_err) begin
            r_mismatch <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_msg_rx
// Description : Scoreboard bench for uart_msg_rx. A fast-baud instance carries
//               the line traffic; a default-parameter instance checks real
//               115200 baud timing and glitch rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_msg_rx;

   localparam int BC     = 2;     // 1 MHz / 500000 baud
   localparam int BC_DEF = 234;   // 27 MHz / 115200 baud

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_pin;
   logic       rx_pin_def;
   logic [7:0] rx_data, rx_data_d;
   logic       rx_data_valid, rx_data_valid_d;
   logic       rx_frame_err, rx_frame_err_d;
   logic       msg_valid, msg_valid_d;
   logic       msg_ok, msg_ok_d;
   logic [7:0] msg_letter, msg_letter_d;
   logic [7:0] msg_count, msg_count_d;

   always #5 clk = ~clk;

   uart_msg_rx #(.CLK_FRE(1), .BAUD_RATE(500000)) dut (
      .clk(clk), .reset(reset), .rx_pin(rx_pin),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .rx_frame_err(rx_frame_err), .msg_valid(msg_valid),
      .msg_ok(msg_ok), .msg_letter(msg_letter), .msg_count(msg_count)
   );

   uart_msg_rx dut_def (
      .clk(clk), .reset(reset), .rx_pin(rx_pin_def),
      .rx_data(rx_data_d), .rx_data_valid(rx_data_valid_d),
      .rx_frame_err(rx_frame_err_d), .msg_valid(msg_valid_d),
      .msg_ok(msg_ok_d), .msg_letter(msg_letter_d), .msg_count(msg_count_d)
   );

   int total = 0;
   int bad   = 0;

   typedef struct { bit is_err; logic [7:0] data; } ev_t;
   typedef struct { bit ok; logic [7:0] letter; logic [7:0] count; } msg_t;
   ev_t        ev_q[$];
   msg_t       msg_q[$];
   logic [7:0] def_q[$];

   // Reference model state: the current line as a byte list.
   logic [7:0] line[$];
   bit         line_bad;
   logic [7:0] m_letter;
   int         m_count;
   logic [7:0] last_good;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flag_unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: got a pulse expected none", name);
   endtask

   function automatic bit line_good();
      string g = "Hello World ";
      if (line_bad || line.size() != 14) return 1'b0;
      for (int i = 0; i < 12; i++) if (line[i] != g[i]) return 1'b0;
      if (line[12] < 8'h41 || line[12] > 8'h5A) return 1'b0;
      return line[13] == 8'h0D;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      bit ok;
      if (b == 8'h0A) begin
         ok = line_good();
         if (ok) begin
            m_letter = line[12];
            m_count  = (m_count + 1) % 256;
         end
         msg_q.push_back('{ok, m_letter, 8'(m_count)});
         line.delete();
         line_bad = 1'b0;
      end else begin
         line.push_back(b);
      end
   endtask

   task automatic model_reset();
      line.delete();
      line_bad  = 1'b0;
      m_letter  = 8'h00;
      m_count   = 0;
      last_good = 8'h00;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      rx_pin = 1'b0;
      wait_cyc(BC);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         wait_cyc(BC);
      end
      rx_pin = stop;
      wait_cyc(BC);
   endtask

   task automatic drive_def(input logic [7:0] b);
      def_q.push_back(b);
      rx_pin_def = 1'b0;
      wait_cyc(BC_DEF);
      for (int i = 0; i < 8; i++) begin
         rx_pin_def = b[i];
         wait_cyc(BC_DEF);
      end
      rx_pin_def = 1'b1;
      wait_cyc(BC_DEF);
   endtask

   task automatic send_byte(input logic [7:0] b);
      ev_q.push_back('{1'b0, b});
      model_byte(b);
      drive_frame(b, 1'b1);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic send_line(input string s);
      send_str(s);
      send_byte(8'h0D);
      send_byte(8'h0A);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_data"}, rx_data, 0);
      check({tag, "_rx_data_valid"}, rx_data_valid, 0);
      check({tag, "_rx_frame_err"}, rx_frame_err, 0);
      check({tag, "_msg_valid"}, msg_valid, 0);
      check({tag, "_msg_ok"}, msg_ok, 0);
      check({tag, "_msg_letter"}, msg_letter, 0);
      check({tag, "_msg_count"}, msg_count, 0);
   endtask

   // Monitor: pop and compare whenever a DUT presents a pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_data_valid || rx_frame_err) begin
            if (ev_q.size() == 0) begin
               flag_unexpected("byte_event");
            end else begin
               ev_t e;
               e = ev_q.pop_front();
               check("rx_frame_err", rx_frame_err, e.is_err);
               check("rx_data_valid", rx_data_valid, !e.is_err);
               if (!e.is_err) begin
                  check("rx_data", rx_data, e.data);
                  last_good = e.data;
               end else begin
                  check("rx_data_held", rx_data, last_good);
               end
            end
         end
         if (msg_valid) begin
            if (msg_q.size() == 0) begin
               flag_unexpected("msg_valid");
            end else begin
               msg_t m;
               m = msg_q.pop_front();
               check("msg_ok", msg_ok, m.ok);
               check("msg_letter", msg_letter, m.letter);
               check("msg_count", msg_count, m.count);
            end
         end
         if (rx_data_valid_d) begin
            if (def_q.size() == 0) flag_unexpected("def_rx_data_valid");
            else check("def_rx_data", rx_data_d, def_q.pop_front());
         end
         if (rx_frame_err_d) flag_unexpected("def_rx_frame_err");
      end
   end

   initial begin
      logic [7:0] b;
      rx_pin     = 1'b1;
      rx_pin_def = 1'b1;
      reset      = 1'b1;
      model_reset();
      wait_cyc(4);
      check_all_zero("reset");
      reset = 1'b0;
      wait_cyc(4);

      fork
         begin
            // Default-rate instance: one byte, a short glitch, one more byte.
            drive_def(8'h55);
            wait_cyc(BC_DEF * 2);
            rx_pin_def = 1'b0;
            wait_cyc(50);
            rx_pin_def = 1'b1;
            wait_cyc(BC_DEF * 3);
            drive_def(8'hC3);
            wait_cyc(BC_DEF * 2);
         end
         begin
            send_byte(8'h55);
            for (int i = 0; i < 20; i++) begin
               b = 8'($urandom_range(0, 255));
               send_byte(b);
            end
            send_byte(8'h0A);
            send_line("Hello World Q");
            send_line("Hello World 7");
            send_str("Hello Worl");
            send_byte(8'h0A);
            // Stop bit low, then a 3-bit break before the line recovers.
            ev_q.push_back('{1'b1, 8'h00});
            line_bad = 1'b1;
            drive_frame(8'($urandom_range(0, 255)), 1'b0);
            wait_cyc(BC * 3);
            rx_pin = 1'b1;
            wait_cyc(BC * 3);
            send_byte(8'h0A);
         end
      join

      // Enough traffic for the good-line counter to wrap; a few lines carry
      // a lowercase letter and must be rejected.
      for (int i = 0; i < 261; i++) begin
         string s;
         if (i % 43 == 7) s = {"Hello World ", string'(8'($urandom_range(8'h61, 8'h7A)))};
         else             s = {"Hello World ", string'(8'($urandom_range(8'h41, 8'h5A)))};
         send_line(s);
      end
      wait_cyc(BC * 12);
      check("msg_count_wrapped", msg_count, 0);

      // Reset in the middle of a byte aborts it silently.
      rx_pin = 1'b0;
      wait_cyc(BC);
      rx_pin = 1'b1;
      wait_cyc(BC * 2);
      reset = 1'b1;
      wait_cyc(3);
      check_all_zero("midreset");
      reset = 1'b0;
      model_reset();
      wait_cyc(BC * 6);
      send_byte(8'hA3);
      send_byte(8'h0A);
      send_line("Hello World Z");
      wait_cyc(BC * 12);

      check("ev_q_drained", ev_q.size(), 0);
      check("msg_q_drained", msg_q.size(), 0);
      check("def_q_drained", def_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
